// File: rtl/retire_wb_lrsc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | retire_wb_lrsc : retire/write-back stage with variable-latency load stall  |
// |                  and an LR/SC reservation (granule, timeout, snoop kill).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package retire_wb_lrsc_pkg;
    typedef enum logic [3:0] {
        NOP, ALU, LB, LBU, LH, LHU, LW, LR_W, SC_W, SB, SW, BRANCH
    } iType_e;
endpackage

module retire_wb_lrsc
    import retire_wb_lrsc_pkg::*;
#(
    parameter int GRANULE_BITS = 2,
    parameter int RES_TIMEOUT  = 64,
    parameter int CNT_WIDTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid_i,
    input  iType_e      instruction_operation_i,
    input  logic        writes_rd_i,
    input  logic [31:0] result_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_data_i,
    input  logic        inval_i,
    input  logic [31:0] inval_addr_i,
    output logic        stall_o,
    output logic        regbank_we_o,
    output logic [31:0] regbank_data_o,
    output logic        sc_success_o,
    output logic        reservation_valid_o,
    output logic [31:0] reservation_addr_o,
    output logic        retired_o
);

    localparam logic [31:0]          GRANULE_MASK = ~((32'd1 << GRANULE_BITS) - 32'd1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT      = CNT_WIDTH'(RES_TIMEOUT);

    typedef enum logic [0:0] {IDLE, WAIT_MEM} state_e;

    state_e               state_q, state_d;
    iType_e               op_q, op_d;
    logic                 wrd_q, wrd_d;
    logic [31:0]          addr_q, addr_d;
    logic                 res_valid_q, res_valid_d;
    logic [31:0]          res_addr_q, res_addr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    iType_e      cur_op;
    logic        cur_wrd;
    logic [31:0] cur_addr;
    logic        complete;
    logic        stall;
    logic        sc_success;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] wb_data;

    function automatic logic is_load(input iType_e op);
        return op inside {LB, LBU, LH, LHU, LW, LR_W};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= NOP;
            wrd_q       <= 1'b0;
            addr_q      <= '0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wrd_q       <= wrd_d;
            addr_q      <= addr_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wrd_d    = wrd_q;
        addr_d   = addr_q;
        cur_op   = instruction_operation_i;
        cur_wrd  = writes_rd_i;
        cur_addr = result_i;
        complete = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid_i) begin
                    if (is_load(instruction_operation_i) && !mem_rvalid_i) begin
                        stall   = 1'b1;
                        state_d = WAIT_MEM;
                        op_d    = instruction_operation_i;
                        wrd_d   = writes_rd_i;
                        addr_d  = result_i;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                cur_op   = op_q;
                cur_wrd  = wrd_q;
                cur_addr = addr_q;
                if (mem_rvalid_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (cur_addr[1:0])
            2'd0:    ld_byte = mem_data_i[7:0];
            2'd1:    ld_byte = mem_data_i[15:8];
            2'd2:    ld_byte = mem_data_i[23:16];
            default: ld_byte = mem_data_i[31:24];
        endcase
        ld_half    = cur_addr[1] ? mem_data_i[31:16] : mem_data_i[15:0];
        sc_success = complete && (cur_op == SC_W) && res_valid_q
                     && ((cur_addr & GRANULE_MASK) == res_addr_q);
        case (cur_op)
            LB:        wb_data = {{24{ld_byte[7]}}, ld_byte};
            LBU:       wb_data = {24'd0, ld_byte};
            LH:        wb_data = {{16{ld_half[15]}}, ld_half};
            LHU:       wb_data = {16'd0, ld_half};
            LW, LR_W:  wb_data = mem_data_i;
            SC_W:      wb_data = {31'd0, ~sc_success};
            default:   wb_data = result_i;
        endcase
    end

    // Priority low to high: timeout, snoop/SC kill, LR set.
    always_comb begin
        res_valid_d = res_valid_q;
        res_addr_d  = res_addr_q;
        cnt_d       = cnt_q;
        if (res_valid_q && (TIMEOUT != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(1)) begin
                res_valid_d = 1'b0;
            end
        end
        if ((inval_i && ((inval_addr_i & GRANULE_MASK) == res_addr_q))
            || (complete && (cur_op == SC_W))) begin
            res_valid_d = 1'b0;
        end
        if (complete && (cur_op == LR_W)) begin
            res_valid_d = 1'b1;
            res_addr_d  = cur_addr & GRANULE_MASK;
            cnt_d       = TIMEOUT;
        end
    end

    // Outputs are masked while reset is held so nothing retires mid-reset.
    assign stall_o             = stall & ~reset;
    assign retired_o           = complete & ~reset;
    assign regbank_we_o        = complete & cur_wrd & ~reset;
    assign regbank_data_o      = (complete && !reset) ? wb_data : 32'd0;
    assign sc_success_o        = sc_success & ~reset;
    assign reservation_valid_o = res_valid_q;
    assign reservation_addr_o  = res_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_retire_wb_lrsc.sv
`default_nettype none
// Testbench for retire_wb_lrsc: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_retire_wb_lrsc;
    import retire_wb_lrsc_pkg::*;

    localparam int G  = 2;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid_i;
    iType_e      instruction_operation_i;
    logic        writes_rd_i;
    logic [31:0] result_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_data_i;
    logic        inval_i;
    logic [31:0] inval_addr_i;
    logic        stall_o, regbank_we_o, sc_success_o, reservation_valid_o, retired_o;
    logic [31:0] regbank_data_o, reservation_addr_o;

    int total = 0;
    int bad   = 0;

    retire_wb_lrsc #(.GRANULE_BITS(G), .RES_TIMEOUT(TO), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .instr_valid_i(instr_valid_i), .instruction_operation_i(instruction_operation_i),
        .writes_rd_i(writes_rd_i), .result_i(result_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_data_i(mem_data_i),
        .inval_i(inval_i), .inval_addr_i(inval_addr_i),
        .stall_o(stall_o), .regbank_we_o(regbank_we_o), .regbank_data_o(regbank_data_o),
        .sc_success_o(sc_success_o), .reservation_valid_o(reservation_valid_o),
        .reservation_addr_o(reservation_addr_o), .retired_o(retired_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gran(input logic [31:0] a);
        return a & ~((32'd1 << G) - 32'd1);
    endfunction

    function automatic bit is_ld(input iType_e op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW) || (op == LR_W);
    endfunction

    function automatic logic [31:0] load_val(input iType_e op, input logic [31:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * a[1:0]));
        h = 16'(w >> (16 * a[1]));
        case (op)
            LB:      return 32'($signed(b));
            LBU:     return 32'(b);
            LH:      return 32'($signed(h));
            LHU:     return 32'(h);
            default: return w;
        endcase
    endfunction

    // Behavioural model: a pending-load record and a reservation remembered
    // by the cycle its LR completed; it lives for TO cycles after that.
    int          cyc = 0;
    bit          m_pend = 0;
    iType_e      m_op = NOP;
    bit          m_wrd = 0;
    logic [31:0] m_addr = '0;
    bit          m_res = 0;
    logic [31:0] m_raddr = '0;
    int          m_lrc = 0;

    always @(negedge clk) begin
        bit          present, wrd, e_stall, e_done, e_rv, e_sc;
        iType_e      op;
        logic [31:0] addr, e_data;
        cyc++;
        if (reset) begin
            chk("rst_stall", {31'd0, stall_o}, 0);
            chk("rst_we", {31'd0, regbank_we_o}, 0);
            chk("rst_data", regbank_data_o, 0);
            chk("rst_ret", {31'd0, retired_o}, 0);
            chk("rst_rv", {31'd0, reservation_valid_o}, 0);
            m_pend = 0; m_res = 0; m_raddr = '0;
        end else begin
            present = m_pend ? 1'b1 : instr_valid_i;
            op      = m_pend ? m_op : instruction_operation_i;
            wrd     = m_pend ? m_wrd : writes_rd_i;
            addr    = m_pend ? m_addr : result_i;
            e_stall = present && is_ld(op) && !mem_rvalid_i;
            e_done  = present && !e_stall;
            e_rv    = m_res && (cyc <= m_lrc + TO);
            e_sc    = e_done && (op == SC_W) && e_rv && (gran(addr) == m_raddr);
            if (is_ld(op))        e_data = load_val(op, addr, mem_data_i);
            else if (op == SC_W)  e_data = e_sc ? 32'd0 : 32'd1;
            else                  e_data = result_i;
            chk("stall", {31'd0, stall_o}, {31'd0, e_stall});
            chk("retired", {31'd0, retired_o}, {31'd0, e_done});
            chk("we", {31'd0, regbank_we_o}, {31'd0, e_done && wrd});
            chk("sc_success", {31'd0, sc_success_o}, {31'd0, e_sc});
            chk("res_valid", {31'd0, reservation_valid_o}, {31'd0, e_rv});
            chk("res_addr", reservation_addr_o, m_raddr);
            if (e_done) chk("wb_data", regbank_data_o, e_data);
            if (e_stall && !m_pend) begin
                m_op = op; m_wrd = wrd; m_addr = addr;
            end
            m_pend = e_stall;
            if (!e_rv) m_res = 0;
            if (e_done && op == LR_W) begin
                m_res = 1; m_raddr = gran(addr); m_lrc = cyc;
            end else if ((e_done && op == SC_W) || (inval_i && gran(inval_addr_i) == m_raddr)) begin
                m_res = 0;
            end
        end
    end

    task automatic set_in(input bit v, input iType_e op, input bit wrd, input logic [31:0] res,
                          input bit rv, input logic [31:0] d, input bit inv, input logic [31:0] ia);
        instr_valid_i = v; instruction_operation_i = op; writes_rd_i = wrd; result_i = res;
        mem_rvalid_i = rv; mem_data_i = d; inval_i = inv; inval_addr_i = ia;
    endtask

    task automatic idle_in();
        set_in(0, NOP, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    iType_e ops[12] = '{NOP, ALU, LB, LBU, LH, LHU, LW, LR_W, SC_W, SB, SW, BRANCH};

    initial begin
        int stalls;
        reset = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_stall", {31'd0, stall_o}, 0);
        chk("reset_rv", {31'd0, reservation_valid_o}, 0);
        chk("reset_raddr", reservation_addr_o, 0);
        tick(); reset = 1'b0;

        // LBU same-cycle response
        set_in(1, LBU, 1, 32'h1003, 1, 32'h80FF_1234, 0, 0); #2;
        chk("lbu_we", {31'd0, regbank_we_o}, 1);
        chk("lbu_data", regbank_data_o, 32'h0000_0080);
        chk("lbu_stall", {31'd0, stall_o}, 0);
        chk("lbu_ret", {31'd0, retired_o}, 1);
        tick(); idle_in(); #2;
        chk("lbu_ret_pulse", {31'd0, retired_o}, 0);

        // LH with three-cycle-late response
        tick(); stalls = 0;
        for (int k = 0; k < 3; k++) begin
            set_in(1, LH, 1, 32'h2002, 0, 32'h8001_0000, 0, 0); #2;
            if (stall_o) stalls++;
            chk("lh_noret", {31'd0, retired_o}, 0);
            tick();
        end
        set_in(1, LH, 1, 32'h2002, 1, 32'h8001_0000, 0, 0); #2;
        chk("lh_stall_cnt", stalls, 3);
        chk("lh_stall_end", {31'd0, stall_o}, 0);
        chk("lh_data", regbank_data_o, 32'hFFFF_8001);
        chk("lh_we", {31'd0, regbank_we_o}, 1);

        // LR then SC success, second SC fails
        tick(); set_in(1, LR_W, 1, 32'h4000, 1, 32'hDEAD_BEEF, 0, 0); #2;
        chk("lr_data", regbank_data_o, 32'hDEAD_BEEF);
        tick(); set_in(1, SC_W, 1, 32'h4002, 0, 0, 0, 0); #2;
        chk("sc1_rv", {31'd0, reservation_valid_o}, 1);
        chk("sc1_ok", {31'd0, sc_success_o}, 1);
        chk("sc1_data", regbank_data_o, 0);
        tick(); set_in(1, SC_W, 1, 32'h4002, 0, 0, 0, 0); #2;
        chk("sc2_ok", {31'd0, sc_success_o}, 0);
        chk("sc2_data", regbank_data_o, 1);

        // Snoop invalidate
        tick(); set_in(1, LR_W, 1, 32'h4000, 1, 0, 0, 0);
        tick(); set_in(0, NOP, 0, 0, 0, 0, 1, 32'h4001); #2;
        chk("inv_rv_before", {31'd0, reservation_valid_o}, 1);
        tick(); set_in(1, SC_W, 1, 32'h4000, 0, 0, 0, 0); #2;
        chk("inv_rv_after", {31'd0, reservation_valid_o}, 0);
        chk("inv_sc_data", regbank_data_o, 1);

        // Timeout
        tick(); set_in(1, LR_W, 1, 32'h4000, 1, 0, 0, 0);
        repeat (6) begin tick(); idle_in(); end
        tick(); set_in(1, SC_W, 1, 32'h4000, 0, 0, 0, 0); #2;
        chk("to_late_ok", {31'd0, sc_success_o}, 0);
        chk("to_late_data", regbank_data_o, 1);
        tick(); set_in(1, LR_W, 1, 32'h4000, 1, 0, 0, 0);
        tick(); idle_in();
        tick(); set_in(1, SC_W, 1, 32'h4000, 0, 0, 0, 0); #2;
        chk("to_early_ok", {31'd0, sc_success_o}, 1);

        // Reset during WAIT_MEM with a reservation held
        tick(); set_in(1, LR_W, 1, 32'h4000, 1, 0, 0, 0);
        tick(); set_in(1, LW, 1, 32'h5000, 0, 0, 0, 0); #2;
        chk("wm_stall", {31'd0, stall_o}, 1);
        tick(); reset = 1'b1; set_in(0, NOP, 0, 0, 1, 32'h1234_5678, 0, 0); #2;
        chk("wm_rst_we", {31'd0, regbank_we_o}, 0);
        chk("wm_rst_ret", {31'd0, retired_o}, 0);
        chk("wm_rst_rv", {31'd0, reservation_valid_o}, 0);
        chk("wm_rst_stall", {31'd0, stall_o}, 0);
        tick(); reset = 1'b0; idle_in();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset = ($urandom_range(0, 199) == 0);
            set_in($urandom_range(0, 3) != 0, ops[$urandom_range(0, 11)], 1'($urandom),
                   32'h4000 + 32'($urandom_range(0, 31)), 1'($urandom), $urandom,
                   $urandom_range(0, 9) == 0, 32'h4000 + 32'($urandom_range(0, 31)));
        end
        tick(); reset = 1'b0; idle_in();
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
